// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: registered add/sub/and, multi-cycle shift-add multiply
module alu_seq #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            operation,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  carry,
  output logic                  zero,
  output logic                  negative,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state, state_next;
  logic [2*W-1:0]  mcand, acc, acc_step;
  logic [W-1:0]    mplier;
  logic [CW-1:0]   count;
  logic [W:0]      sum, diff;
  logic [W-1:0]    res_next;
  logic            carry_next;
  logic            issue_single, issue_mul, mul_last, update;

  always_comb begin
    state_next   = state;
    issue_single = 1'b0;
    issue_mul    = 1'b0;
    mul_last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (operation == OP_MUL) begin
            issue_mul  = 1'b1;
            state_next = MUL;
          end else begin
            issue_single = 1'b1;
          end
        end
      end
      MUL: begin
        // count still holds the number of iterations done before this edge
        if (count == CW'(W - 1)) begin
          mul_last   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sum        = {1'b0, A_in} + {1'b0, B_in};
    diff       = {1'b0, A_in} - {1'b0, B_in};
    acc_step   = mplier[0] ? (acc + mcand) : acc;
    res_next   = '0;
    carry_next = 1'b0;
    if (mul_last) begin
      res_next   = acc_step[W-1:0];
      carry_next = |acc_step[2*W-1:W];
    end else begin
      case (operation)
        OP_ADD: begin
          res_next   = sum[W-1:0];
          carry_next = sum[W];
        end
        OP_SUB: begin
          res_next   = diff[W-1:0];
          carry_next = diff[W];
        end
        OP_AND: begin
          res_next   = A_in & B_in;
          carry_next = 1'b0;
        end
        default: begin
          res_next   = '0;
          carry_next = 1'b0;
        end
      endcase
    end
    update = issue_single | mul_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      alu_out  <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == MUL);
      done  <= update;
      if (update) begin
        alu_out  <= res_next;
        carry    <= carry_next;
        zero     <= (res_next == '0);
        negative <= res_next[W-1];
      end
      if (issue_mul) begin
        mcand  <= {{W{1'b0}}, A_in};
        mplier <= B_in;
        acc    <= '0;
        count  <= '0;
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic model
module tb_alu_seq;

  localparam int W   = 11;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   operation;
  logic [W-1:0] A_in, B_in;
  logic [W-1:0] alu_out;
  logic         carry, zero, negative, busy, done;

  int n_checks = 0;
  int n_err    = 0;
  int exp_out  = 0;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .A_in(A_in), .B_in(B_in), .alu_out(alu_out), .carry(carry),
    .zero(zero), .negative(negative), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands
  task automatic model(input logic [1:0] op, input int a, input int b,
                       output int res, output int cy);
    int full;
    case (op)
      2'b00: begin full = a + b; res = full % MOD; cy = (full >= MOD) ? 1 : 0; end
      2'b01: begin res = (a - b + MOD) % MOD; cy = (a < b) ? 1 : 0; end
      2'b10: begin full = a * b; res = full % MOD; cy = (full >= MOD) ? 1 : 0; end
      default: begin res = a & b; cy = 0; end
    endcase
  endtask

  task automatic chk_result(input string tag, input int res, input int cy);
    chk({tag, "_out"}, alu_out, res);
    chk({tag, "_carry"}, carry, cy);
    chk({tag, "_zero"}, zero, (res == 0) ? 1 : 0);
    chk({tag, "_neg"}, negative, (res >= MOD / 2) ? 1 : 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input int a, input int b);
    int res, cy;
    model(op, a, b, res, cy);
    start = 1'b1; operation = op; A_in = W'(a); B_in = W'(b);
    step();
    start = 1'b0;
    if (op == 2'b10) begin
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_done0"}, done, 0);
      for (int i = 1; i < W; i++) begin
        step();
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_nodone"}, done, 0);
        chk({tag, "_hold"}, alu_out, exp_out);
      end
      step();
    end
    chk_result(tag, res, cy);
    exp_out = res;
    step();
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int res, cy;
    reset = 1'b1; start = 1'b0; operation = 2'b00; A_in = '0; B_in = '0;
    #1;
    chk("rst_out", alu_out, 0);
    chk("rst_flags", {carry, zero, negative, busy, done}, 0);
    step();
    reset = 1'b0;
    step();

    run_op("add_ovf", 2'b00, 2000, 100);
    chk("add_ovf_value", alu_out, 52);

    reset = 1'b1;
    #2;
    chk("async_rst_out", alu_out, 0);
    chk("async_rst_flags", {carry, zero, negative, busy, done}, 0);
    #1;
    reset = 1'b0;
    exp_out = 0;
    step();

    run_op("sub_borrow", 2'b01, 5, 7);
    chk("sub_borrow_value", alu_out, 2046);
    run_op("sub_zero", 2'b01, 7, 7);
    run_op("mul_45", 2'b10, 45, 45);
    chk("mul_45_value", alu_out, 2025);
    run_op("mul_64", 2'b10, 64, 64);

    // start requested during busy and held through completion
    start = 1'b1; operation = 2'b10; A_in = 3; B_in = 5;
    step();
    chk("ign_busy", busy, 1);
    operation = 2'b00; A_in = 1; B_in = 1;
    for (int i = 1; i < W; i++) begin
      step();
      chk("ign_nodone", done, 0);
      chk("ign_hold", alu_out, exp_out);
    end
    step();
    chk_result("ign_mul", 15, 0);
    step();
    start = 1'b0;
    chk_result("ign_add", 2, 0);
    exp_out = 2;
    step();
    chk("ign_pulse", done, 0);

    // reset four cycles into a multiply
    start = 1'b1; operation = 2'b10; A_in = 100; B_in = 3;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    #2;
    chk("mulrst_out", alu_out, 0);
    chk("mulrst_flags", {carry, zero, negative, busy, done}, 0);
    #1;
    reset = 1'b0;
    exp_out = 0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("mulrst_nodone", done, 0);
      chk("mulrst_idle", busy, 0);
    end
    run_op("and", 2'b11, 12'h7F0, 12'h0FF);
    chk("and_value", alu_out, 12'h0F0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      int a, b;
      op = 2'($urandom_range(0, 3));
      a  = (n % 8 == 0) ? MOD - 1 : int'($urandom_range(0, MOD - 1));
      b  = (n % 8 == 1) ? 0 : int'($urandom_range(0, MOD - 1));
      run_op("rand", op, a, b);
    end

    // back-to-back single-cycle ops keep done high
    model(2'b00, 10, 20, res, cy);
    start = 1'b1; operation = 2'b00; A_in = 10; B_in = 20;
    step();
    chk_result("b2b_first", res, cy);
    model(2'b11, 12'h555, 12'h3C3, res, cy);
    operation = 2'b11; A_in = W'(12'h555); B_in = W'(12'h3C3);
    step();
    start = 1'b0;
    chk_result("b2b_second", res, cy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
